key_conditioner: RTL and testbench
==================================

Name: key_conditioner

Overview:
- Conditions the raw active-low push-buttons before they reach the lock core's key inputs.
- Per key: synchronises the pin, debounces it, and produces a clean active-high level plus single-cycle press and release pulses.
- Sits between the board key pins and the lock top wrapper. Replaces the bare inversion of raw pins with debounced pulses the lock FSM can consume directly.

Parameters:
- N_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronised input must differ from the stable state before the state flips (10 ms at 100 MHz); legal range >= 1.
- REPEAT_DELAY, 50_000_000: cycles from press pulse to first auto-repeat pulse; used only with KEY_REPEAT_EN.
- REPEAT_PERIOD, 10_000_000: cycles between subsequent auto-repeat pulses; used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- key_n  in  N_KEYS  raw button pins, active-low, asynchronous to clk
- key_level  out  N_KEYS  debounced key state, 1 = pressed
- key_press  out  N_KEYS  one-cycle pulse per press event (and per repeat when enabled)
- key_release  out  N_KEYS  one-cycle pulse per release event
- key_any  out  1  OR of key_press, registered alongside it

Behaviour:
- Reset:
  - sync flops = 1 (released); counters = 0; key_level = 0; key_press = 0; key_release = 0; key_any = 0; repeat counters = 0.
- Synchroniser: two-flop chain per bit; s = ~key_n after 2 stages.
- Debounce, per channel, independent:
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - If s == key_level, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s still differs, on that edge: key_level toggles and the counter clears.
- Latency: a pin held low from before edge k gives key_level = 1 after edge k+1+DEBOUNCE_CYCLES, i.e. 2 sync stages + DEBOUNCE_CYCLES edges. The same latency applies on release.
- Glitches: any excursion lasting fewer than DEBOUNCE_CYCLES synchronised cycles gives no change to any output, and the counter returns to 0.
- Pulses:
  - key_press[i] = 1 for exactly the single cycle in which key_level[i] is first 1.
  - key_release[i] = 1 for exactly the cycle key_level[i] is first 0.
  - Both are registered, never asserted together.
- Simultaneous events: several channels may pulse in the same cycle; key_any = 1 in that cycle only.
- Reset mid-operation: all state is discarded immediately (async). A key still held at reset release is reported as a fresh press after the full latency. No release pulse is generated for a key lost by reset.
- No state machine beyond the per-channel 2-state stable level; the counter saturates never, it is cleared on match or flip.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined: a per-channel repeat counter starts at the press pulse. While key_level stays 1:
  - key_press re-pulses REPEAT_DELAY cycles after the original press;
  - then every REPEAT_PERIOD cycles.
  - Release clears the repeat counter in the same cycle key_level falls, so no repeat pulse coincides with key_release.
  - key_any follows repeat pulses.
- Undefined: exactly one key_press per physical press; repeat logic and REPEAT_* parameters unused and synthesised away.

Decomposition:
- Shared header lock_pkg.vh: default DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD constants; key index constants KEY_ENTER/KEY_CLEAR/KEY_MODE/KEY_BACK (0..3), so this block and the lock core agree on key meaning.
- Sub-module key_debounce_ch: one channel containing synchroniser, counter, level, pulses and optional repeat. The top instantiates N_KEYS copies via generate and ORs the pulses into key_any.

Test Plan (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_KEYS=4):
- Reset, all key_n=1 -> all outputs 0 for 100 cycles.
- key_n[0] low at cycle 10, held -> key_level[0] rises after edge 10+1+8 = 19, key_press[0] high that one cycle only, key_any high same cycle; later release gives key_release[0] after the same 10-edge latency.
- key_n[1] low pulses of 3, 7 synchronised cycles, each followed by 2 high -> no output change ever.
- key_n[2] and key_n[3] low on the same edge -> both key_press bits and key_any assert in the same single cycle.
- key_n[0] held low, rst pulsed mid-count and again after key_level=1 -> outputs 0 immediately, no key_release; key_press re-fires 10 edges after rst deasserts.
- KEY_REPEAT_EN defined, key_n[0] held 60 cycles past press -> key_press[0] at press, +20, +25, +30, ... until release, with no pulse on the release cycle. Undefined -> single pulse only.

Source files
------------

// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the key conditioner and the lock core.
// Key index constants give both blocks the same meaning for each key.
package key_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    localparam int DEFAULT_REPEAT_DELAY    = 50_000_000;
    localparam int DEFAULT_REPEAT_PERIOD   = 10_000_000;

    localparam int KEY_ENTER = 0;
    localparam int KEY_CLEAR = 1;
    localparam int KEY_MODE  = 2;
    localparam int KEY_BACK  = 3;

    typedef enum logic {
        LVL_UP   = 1'b0,
        LVL_DOWN = 1'b1
    } key_state_e;

    // Width of a counter that must hold values 0..max_count.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce counter, stable level, press/release pulses.
// Auto-repeat of press pulses is present only when KEY_REPEAT_EN is defined.
//
// state    | meaning
// ---------+---------------------------
// LVL_UP   | key debounced as released
// LVL_DOWN | key debounced as pressed
module key_debounce_ch
    import key_conditioner_pkg::*;
#(
`ifdef KEY_REPEAT_EN
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
`endif
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic press_set
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_1, sync_2, pressed_s;
    key_state_e    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          flip, rise, fall, rep_fire;

    // Flops reset to the released pin level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    assign pressed_s = ~sync_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LVL_UP;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        flip      = 1'b0;
        if (pressed_s != logic'(state)) begin
            if (cnt == CNT_LAST) begin
                flip      = 1'b1;
                state_nxt = (state == LVL_UP) ? LVL_DOWN : LVL_UP;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign rise = flip && (state == LVL_UP);
    assign fall = flip && (state == LVL_DOWN);

`ifdef KEY_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int            RW        = cnt_width(RPT_MAX);
    localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_cnt;
    logic          held;

    // Held and not releasing on this edge; the release edge never fires a repeat.
    assign held     = (state == LVL_DOWN) && !fall;
    assign rep_fire = held && (rpt_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt <= '0;
        end else if (rise) begin
            rpt_cnt <= RPT_FIRST;
        end else if (held) begin
            rpt_cnt <= (rpt_cnt == '0) ? RPT_NEXT : rpt_cnt - 1'b1;
        end else begin
            rpt_cnt <= '0;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    assign press_set = rise | rep_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= press_set;
            release_pulse <= fall;
        end
    end

    assign level = logic'(state);

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner: N_KEYS debounced channels with press/release pulses and a registered key_any.
// Define KEY_REPEAT_EN to add auto-repeat press pulses while a key stays held.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_any
);

    logic [N_KEYS-1:0] press_set;

    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
`ifdef KEY_REPEAT_EN
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
`endif
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .key_n         (key_n[i]),
            .level         (key_level[i]),
            .press         (key_press[i]),
            .release_pulse (key_release[i]),
            .press_set     (press_set[i])
        );
    end

    // Built from the same next-state terms as key_press so both land on one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_any <= 1'b0;
        else     key_any <= |press_set;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table, hand sequences for reset/latency/repeat,
// and random key activity checked every cycle against a window-based reference model.
module tb_key_conditioner;

    localparam int N  = 4;
    localparam int DC = 8;
    localparam int RD = 20;
    localparam int RP = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] key_n = '1;
    logic [N-1:0] key_level, key_press, key_release;
    logic         key_any;

    key_conditioner #(
        .N_KEYS          (N),
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_any     (key_any)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Reference model: level flips once the last DC synchronised samples all disagree with it.
    logic [N-1:0] m_p1, m_p2, m_level, m_press, m_release;
    logic         m_any;
    bit           m_win[N][$];
    int           m_age[N];

    task automatic model_reset();
        m_p1 = '1; m_p2 = '1;
        m_level = '0; m_press = '0; m_release = '0; m_any = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_win[i].delete();
            m_age[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [N-1:0] kn);
        bit s, all_diff;
        for (int i = 0; i < N; i++) begin
            s = ~m_p2[i];
            m_win[i].push_back(s);
            if (m_win[i].size() > DC) void'(m_win[i].pop_front());
            m_press[i] = 1'b0;
            m_release[i] = 1'b0;
            all_diff = (m_win[i].size() == DC);
            foreach (m_win[i][j]) if (m_win[i][j] == m_level[i]) all_diff = 0;
            if (all_diff) begin
                m_level[i] = ~m_level[i];
                m_win[i].delete();
                if (m_level[i]) begin m_press[i] = 1'b1; m_age[i] = 0; end
                else m_release[i] = 1'b1;
            end else if (m_level[i]) begin
                m_age[i]++;
`ifdef KEY_REPEAT_EN
                if (m_age[i] >= RD && (m_age[i] - RD) % RP == 0) m_press[i] = 1'b1;
`endif
            end
        end
        m_p2 = m_p1;
        m_p1 = kn;
        m_any = |m_press;
    endtask

    task automatic check_model(input string name);
        logic [3*N:0] got, exp;
        got = {key_level, key_press, key_release, key_any};
        exp = {m_level, m_press, m_release, m_any};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d lvl/press/rel/any actual=%b required=%b", name, edge_n, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, got, exp);
        end
    endtask

    // Drive pins, clock one edge, then compare at the following falling edge.
    task automatic tick(input logic [N-1:0] kn, input string name = "cycle");
        key_n = kn;
        @(posedge clk);
        if (!rst) begin
            model_edge(kn);
            edge_n++;
        end
        @(negedge clk);
        check_model(name);
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        model_reset();
        #1;
        check_int("reset_immediate_outputs", int'({key_level, key_press, key_release, key_any}), 0);
        repeat (hold) tick(key_n, "in_reset");
        rst = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_press(input int ch, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(key_n);
            if (key_press[ch]) begin at = edge_n; break; end
        end
    endtask

    task automatic wait_release(input int ch, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            tick(key_n);
            if (key_release[ch]) begin at = edge_n; break; end
        end
    endtask

    typedef struct {
        logic [N-1:0] kn;
        int           cycles;
        logic [N-1:0] exp_level;
    } vec_t;

    vec_t         vecs[$];
    int           at, start, n_press, n_rel;
    logic [N-1:0] rkn;
    int           rlen;
    logic [N-1:0] kn0_low;

    initial begin
        kn0_low = 4'b1110;
        vecs = '{
            '{4'b1111, 20, 4'b0000},
            '{4'b1110, 12, 4'b0001},
            '{4'b1111, 12, 4'b0000},
            '{4'b1101,  3, 4'b0000},
            '{4'b1111,  2, 4'b0000},
            '{4'b1101,  7, 4'b0000},
            '{4'b1111,  2, 4'b0000},
            '{4'b1111, 12, 4'b0000},
            '{4'b0011, 12, 4'b1100},
            '{4'b1111, 12, 4'b0000},
            '{4'b0110,  9, 4'b0000},
            '{4'b0110,  1, 4'b1001},
            '{4'b1111,  9, 4'b1001},
            '{4'b1111,  1, 4'b0000}
        };

        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle after reset: everything stays low.
        repeat (100) tick('1, "idle");

        // Press on channel 0 before edge 10 of a fresh run.
        do_reset(2);
        repeat (9) tick('1);
        key_n = kn0_low;
        wait_press(0, 30, at);
        check_int("press0_edge", at, 19);
        check_int("press0_any", int'(key_any), 1);
        tick(key_n);
        check_int("press0_single_cycle", int'(key_press[0]), 0);
        repeat (5) tick(key_n);
        start = edge_n + 1;
        key_n = '1;
        wait_release(0, 30, at);
        check_int("release0_latency", at - start, DC + 1);
        repeat (12) tick('1);

        // Table of level patterns, glitches and simultaneous presses.
        do_reset(2);
        foreach (vecs[v]) begin
            repeat (vecs[v].cycles) tick(vecs[v].kn, "vector");
            check_int($sformatf("vec%0d_level", v), int'(key_level), int'(vecs[v].exp_level));
        end

        // Simultaneous press on channels 2 and 3.
        repeat (12) tick(4'b1111);
        key_n = 4'b0011;
        wait_press(2, 30, at);
        check_int("simul_press_bits", int'(key_press), int'(4'b1100));
        check_int("simul_any", int'(key_any), 1);
        tick(key_n);
        check_int("simul_any_one_cycle", int'(key_any), 0);
        repeat (12) tick('1);

        // Reset mid-count, then again after the key is registered as pressed.
        key_n = kn0_low;
        repeat (5) tick(key_n);
        do_reset(3);
        wait_press(0, 30, at);
        check_int("press_after_reset_midcount", at, DC + 2);
        repeat (3) tick(key_n);
        do_reset(2);
        n_rel = 0;
        for (int i = 0; i < 12; i++) begin
            tick(key_n);
            if (key_release[0]) n_rel++;
            if (key_press[0]) begin
                check_int("press_after_reset_held", edge_n, DC + 2);
                break;
            end
        end
        check_int("no_release_on_reset", n_rel, 0);

        // Hold past press: count press pulses over the next 60 edges.
        n_press = 0;
        for (int i = 0; i < 60; i++) begin
            tick(key_n, "hold");
            if (key_press[0]) n_press++;
        end
`ifdef KEY_REPEAT_EN
        check_int("repeat_pulse_count", n_press, 9);
`else
        check_int("repeat_pulse_count", n_press, 0);
`endif
        key_n = '1;
        wait_release(0, 30, at);
        check_int("release_after_hold_no_press", int'(key_press[0]), 0);
        repeat (12) tick('1);

        // Random activity, every cycle against the model.
        for (int b = 0; b < 120; b++) begin
            rkn  = 4'($urandom);
            rlen = $urandom_range(1, 14);
            repeat (rlen) tick(rkn, "random");
            if (b == 60) do_reset(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
